mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips32_pkg.sv | 30 +++
 rtl/mdu_sign_fix.sv | 19 +
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: datapath width, multiply/divide opcodes and MDU state encoding.
package mips32_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] MDU_ITERS = 6'd32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: absolute value of operands, sign restore of results.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         neg_i,
    output logic [W-1:0] result_o
);

    // Negate only when requested; otherwise pass through.
    always_comb begin
        if (neg_i) begin
            result_o = (~value_i) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result_o = value_i;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: 32 radix-2 steps on magnitudes, then a sign-fix cycle.
module mult_div_unit #(
    parameter int WIDTH = mips32_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Div_By_Zero
);

    import mips32_pkg::*;

    mdu_state_e       state_q;
    mdu_op_e          op_q;
    logic [5:0]       cnt_q, cnt_d;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             sign_a_q, sign_b_q, b_zero_q;
    logic [WIDTH-1:0] a_raw_q, opnd_q, hi_w_q, lo_w_q;

    mdu_op_e          in_op_s;
    logic             accept_s, load_sign_a_s, load_sign_b_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, quot_s, rem_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [WIDTH-1:0] iter_hi_s, iter_lo_s, res_hi_s, res_lo_s;
    logic             res_dbz_s;

    assign in_op_s       = mdu_op_e'(Op);
    assign load_sign_a_s = op_is_signed(in_op_s) & Operand_A[WIDTH-1];
    assign load_sign_b_s = op_is_signed(in_op_s) & Operand_B[WIDTH-1];
    assign accept_s      = Start & ~Flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign cnt_d         = (cnt_q == MDU_ITERS) ? cnt_q : cnt_q + 6'd1;

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (.value_i(Operand_A), .neg_i(load_sign_a_s), .result_o(mag_a_s));
    mdu_sign_fix #(.W(WIDTH)) u_abs_b (.value_i(Operand_B), .neg_i(load_sign_b_s), .result_o(mag_b_s));
    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value_i({hi_w_q, lo_w_q}), .neg_i(sign_a_q ^ sign_b_q),
                                            .result_o(prod_s));
    mdu_sign_fix #(.W(WIDTH)) u_fix_quot (.value_i(lo_w_q), .neg_i(sign_a_q ^ sign_b_q), .result_o(quot_s));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.value_i(hi_w_q), .neg_i(sign_a_q), .result_o(rem_s));

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, hi_w_q} + (lo_w_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_w_q, lo_w_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            if (!div_diff_s[WIDTH]) begin
                iter_hi_s = div_diff_s[WIDTH-1:0];
                iter_lo_s = {lo_w_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_hi_s = div_shift_s[WIDTH-1:0];
                iter_lo_s = {lo_w_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            iter_hi_s = mul_sum_s[WIDTH:1];
            iter_lo_s = {mul_sum_s[0], lo_w_q[WIDTH-1:1]};
        end
    end

    // Final result selection, including the architectural divide-by-zero answer.
    always_comb begin
        res_dbz_s = 1'b0;
        if (op_is_div(op_q)) begin
            if (b_zero_q) begin
                res_hi_s  = a_raw_q;
                res_lo_s  = {WIDTH{1'b1}};
                res_dbz_s = 1'b1;
            end else begin
                res_hi_s = rem_s;
                res_lo_s = quot_s;
            end
        end else begin
            {res_hi_s, res_lo_s} = prod_s;
        end
    end

    // Control FSM with registered status outputs and the working datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            hi_w_q   <= {WIDTH{1'b0}};
            lo_w_q   <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    dbz_q  <= 1'b0;
                    if (accept_s) begin
                        state_q  <= ST_ITER;
                        busy_q   <= 1'b1;
                        cnt_q    <= 6'd0;
                        op_q     <= in_op_s;
                        sign_a_q <= load_sign_a_s;
                        sign_b_q <= load_sign_b_s;
                        b_zero_q <= (Operand_B == {WIDTH{1'b0}});
                        a_raw_q  <= Operand_A;
                        hi_w_q   <= {WIDTH{1'b0}};
                        // Divide shifts the dividend out of lo; multiply shifts the multiplier.
                        lo_w_q   <= op_is_div(in_op_s) ? mag_a_s : mag_b_s;
                        opnd_q   <= op_is_div(in_op_s) ? mag_b_s : mag_a_s;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (Flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 6'd0;
                    end else begin
                        hi_w_q <= iter_hi_s;
                        lo_w_q <= iter_lo_s;
                        cnt_q  <= cnt_d;
                        if (cnt_q == MDU_ITERS - 6'd1) begin
                            state_q <= ST_FIX;
                        end else begin
                            state_q <= ST_ITER;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (Flush) begin
                        cnt_q <= 6'd0;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        dbz_q   <= res_dbz_s;
                        hi_q    <= res_hi_s;
                        lo_q    <= res_lo_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops vs arithmetic model, flush/reset sequences.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] Operand_A = 32'd0;
    logic [31:0] Operand_B = 32'd0;
    logic        Flush = 1'b0;
    logic        Busy, Done, Div_By_Zero;
    logic [31:0] HI, LO;

    int pass_cnt = 0;
    int total_cnt = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
        .Operand_A(Operand_A), .Operand_B(Operand_B), .Flush(Flush),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .Div_By_Zero(Div_By_Zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, with the divide-by-zero convention.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (op == 2'b10) begin
                    sq = sa / sb; sr = sa % sb;
                    p = 64'(sq); lo = p[31:0];
                    p = 64'(sr); hi = p[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Called just after an edge; accepts at the next edge k and expects Done at k+33.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int lat;
        Op = op; Operand_A = a; Operand_B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        Op = 2'($urandom); Operand_A = $urandom; Operand_B = $urandom;
        check({name, " busy"}, 64'(Busy), 64'd1);
        lat = 0;
        while (!Done && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " HI"}, 64'(HI), 64'(ehi));
        check({name, " LO"}, 64'(LO), 64'(elo));
        check({name, " dbz"}, 64'(Div_By_Zero), 64'(edbz));
    endtask

    vec_t        vecs[10];
    logic [31:0] mhi, mlo, prev_hi, prev_lo;
    logic        mdbz;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen_done, seen_busy;

    initial begin
        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};

        #1;
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);
        check("reset dbz", 64'(Div_By_Zero), 64'd0);
        Start = 1'b1;
        @(posedge Clk); #1;
        check("no accept in reset", 64'(Busy), 64'd0);
        Start = 1'b0;
        #3 Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed table, issued back-to-back so each Start lands in DONE.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end
        prev_hi = vecs[9].hi; prev_lo = vecs[9].lo;
        @(posedge Clk); #1;
        check("idle Done low", 64'(Done), 64'd0);
        check("idle hold", {HI, LO}, {prev_hi, prev_lo});

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ref_op(rop, ra, rb, mhi, mlo, mdbz);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, mhi, mlo, mdbz);
            prev_hi = mhi; prev_lo = mlo;
        end
        @(posedge Clk); #1;

        // Flush mid-operation with a competing Start.
        Op = 2'b00; Operand_A = 32'd5; Operand_B = 32'd6; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Flush = 1'b1; Start = 1'b1; Op = 2'b01; Operand_A = 32'd9; Operand_B = 32'd9;
        @(posedge Clk); #1;
        Flush = 1'b0; Start = 1'b0;
        check("flush Busy", 64'(Busy), 64'd0);
        check("flush hold", {HI, LO}, {prev_hi, prev_lo});
        seen_done = 0; seen_busy = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done) seen_done++;
            if (Busy) seen_busy++;
        end
        check("flush no Done", 64'(seen_done), 64'd0);
        check("flush Start ignored", 64'(seen_busy), 64'd0);
        check("flush hold later", {HI, LO}, {prev_hi, prev_lo});

        // Reset in the middle of an operation.
        Op = 2'b01; Operand_A = 32'd1000; Operand_B = 32'd1000; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (20) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("mid reset Busy", 64'(Busy), 64'd0);
        check("mid reset HILO", {HI, LO}, 64'd0);
        check("mid reset Done", 64'(Done), 64'd0);
        @(posedge Clk); #3 Reset_n = 1'b1;
        @(posedge Clk); #1;
        run_op("after reset", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
